// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - serial-side inputs and parallel-side outputs of the TDM demux
interface tdm_demux_if #(
    parameter int N_CH  = 8,
    parameter int SEL_W = $clog2(N_CH)
) ();
    logic             in_bit;
    logic             in_valid;
    logic             frame_sync;
    logic [N_CH-1:0]  q;
    logic             q_valid;
    logic [SEL_W-1:0] sel;
    logic             locked;
    logic             sync_err;

    // Link-side driver: sends beats, observes frames and status.
    modport master (
        output in_bit,
        output in_valid,
        output frame_sync,
        input  q,
        input  q_valid,
        input  sel,
        input  locked,
        input  sync_err
    );

    // Demux side: consumes beats, produces frames and status.
    modport slave (
        input  in_bit,
        input  in_valid,
        input  frame_sync,
        output q,
        output q_valid,
        output sel,
        output locked,
        output sync_err
    );
endinterface

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - 8:1 TDM link receiver with frame alignment tracking
module tdm_demux #(
    parameter int N_CH  = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic        clk,
    input  logic        rst,
    tdm_demux_if.slave  bus
);
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // The slot counter must address every channel exactly once per wrap.
    generate
        if (N_CH < 2 || (1 << SEL_W) != N_CH) begin : g_bad_param
            $error("tdm_demux: N_CH must be a power of 2 >= 2 and SEL_W = clog2(N_CH)");
        end
    endgenerate

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

    state_t           state_q,    state_d;
    logic [SEL_W-1:0] sel_q,      sel_d;
    logic [N_CH-1:0]  shadow_q,   shadow_d;
    logic [N_CH-1:0]  q_q,        q_d;
    logic             q_valid_q,  q_valid_d;
    logic             sync_err_q, sync_err_d;

    // State register; reset overrides any beat presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            sel_q      <= '0;
            shadow_q   <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            shadow_q   <= shadow_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Alignment FSM and slot steering; only valid beats can change anything.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        shadow_d   = shadow_q;
        q_d        = q_q;
        q_valid_d  = 1'b0;
        sync_err_d = sync_err_q;

        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Beats before the first marker carry no usable position.
                    if (bus.frame_sync) begin
                        shadow_d    = '0;
                        shadow_d[0] = bus.in_bit;
                        sel_d       = SLOT_ONE;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.frame_sync) begin
                        // A marker anywhere but slot 0 means we slipped; restart
                        // the frame on this beat and drop the partial one.
                        if (sel_q != '0) begin
                            sync_err_d = 1'b1;
                        end
                        shadow_d    = '0;
                        shadow_d[0] = bus.in_bit;
                        sel_d       = SLOT_ONE;
                    end else if (sel_q == '0) begin
                        // Marker missing where it must appear: alignment lost.
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        sel_d      = '0;
                        shadow_d   = '0;
                    end else if (sel_q == LAST_SLOT) begin
                        // Final slot goes straight to the output register.
                        q_d            = shadow_q;
                        q_d[N_CH-1]    = bus.in_bit;
                        q_valid_d      = 1'b1;
                        sel_d          = '0;
                        shadow_d       = '0;
                    end else begin
                        shadow_d[sel_q] = bus.in_bit;
                        sel_d           = sel_q + SLOT_ONE;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    assign bus.q        = q_q;
    assign bus.q_valid  = q_valid_q;
    assign bus.sel      = sel_q;
    assign bus.locked   = (state_q == LOCKED);
    assign bus.sync_err = sync_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - scoreboard bench for the TDM demux
module tb_tdm_demux;
    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    logic clk;
    logic rst;

    tdm_demux_if #(.N_CH(N_CH), .SEL_W(SEL_W)) bus ();

    tdm_demux #(.N_CH(N_CH), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    logic [N_CH-1:0] exp_q[$];
    logic [N_CH-1:0] prev_q;
    logic rst_seen = 1'b1;
    logic [N_CH-1:0] last_q;
    int pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) rst_seen <= rst;

    always @(negedge clk) begin
        if (bus.q_valid === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_q_valid", 32'(bus.q), 32'hFFFF_FFFF);
            end else begin
                last_q = exp_q.pop_front();
                check("q_frame", 32'(bus.q), 32'(last_q));
            end
        end else if (rst_seen === 1'b0) begin
            check("q_hold", 32'(bus.q), 32'(prev_q));
        end
        prev_q = bus.q;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic beat(input logic b, input logic fs);
        bus.in_bit     = b;
        bus.frame_sync = fs;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.in_bit     = 1'b0;
        bus.frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [N_CH-1:0] data, input int gap);
        exp_q.push_back(data);
        for (int k = 0; k < N_CH; k++) begin
            beat(data[k], k == 0);
            idle(gap);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check(tag, {bus.q, bus.q_valid, bus.sel, bus.locked, bus.sync_err}, 32'h0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_bit     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.frame_sync = 1'b0;
        idle(2);
        rst = 1'b0;

        // reset then idle
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_reset_state("reset_idle");
        end

        // contiguous frame, bits 1,0,1,1,0,0,1,0 on slots 0..7
        send_frame(8'b0100_1101, 0);
        @(negedge clk);
        check("t2_q_valid", 32'(bus.q_valid), 32'd1);
        check("t2_q", 32'(bus.q), 32'h4D);
        check("t2_sel", 32'(bus.sel), 32'd0);
        check("t2_locked", 32'(bus.locked), 32'd1);
        check("t2_sync_err", 32'(bus.sync_err), 32'd0);
        @(negedge clk);
        check("t2_pulse_width", 32'(bus.q_valid), 32'd0);

        // two frames with in_valid toggling
        pc = pulse_cnt;
        send_frame(8'hA5, 1);
        @(negedge clk);
        check("t3_q_a5", 32'(bus.q), 32'hA5);
        send_frame(8'h3C, 1);
        idle(2);
        @(negedge clk);
        check("t3_q_3c", 32'(bus.q), 32'h3C);
        check("t3_pulses", 32'(pulse_cnt - pc), 32'd2);

        // early sync at slot 4, then full 0xFF frame
        check("t4_sync_err_pre", 32'(bus.sync_err), 32'd0);
        pc = pulse_cnt;
        beat(1'b0, 1'b1);
        for (int k = 1; k < 4; k++) beat(1'b1, 1'b0);
        check("t4_sel_mid", 32'(bus.sel), 32'd4);
        send_frame(8'hFF, 0);
        idle(1);
        @(negedge clk);
        check("t4_pulses", 32'(pulse_cnt - pc), 32'd1);
        check("t4_sync_err", 32'(bus.sync_err), 32'd1);
        check("t4_locked", 32'(bus.locked), 32'd1);
        check("t4_q", 32'(bus.q), 32'hFF);

        // HUNT discard, good frame, then missing sync
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        pc = pulse_cnt;
        for (int k = 0; k < 8; k++) beat(k[0], 1'b0);
        @(negedge clk);
        check("t5_hunt_sel", 32'(bus.sel), 32'd0);
        check("t5_hunt_locked", 32'(bus.locked), 32'd0);
        check("t5_hunt_sync_err", 32'(bus.sync_err), 32'd0);
        send_frame(8'h81, 0);
        beat(1'b1, 1'b0);
        @(negedge clk);
        check("t5_locked", 32'(bus.locked), 32'd0);
        check("t5_sync_err", 32'(bus.sync_err), 32'd1);
        check("t5_sel", 32'(bus.sel), 32'd0);
        check("t5_q", 32'(bus.q), 32'h81);
        check("t5_pulses", 32'(pulse_cnt - pc), 32'd1);

        // reset at slot 5 wins over a concurrent sync beat
        pc = pulse_cnt;
        beat(1'b1, 1'b1);
        for (int k = 1; k < 5; k++) beat(1'b1, 1'b0);
        check("t6_sel_pre", 32'(bus.sel), 32'd5);
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_bit     = 1'b1;
        bus.frame_sync = 1'b1;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_bit     = 1'b0;
        bus.frame_sync = 1'b0;
        @(negedge clk);
        check_reset_state("t6_after_rst");
        send_frame(8'h0F, 0);
        @(negedge clk);
        check("t6_q", 32'(bus.q), 32'h0F);
        check("t6_locked", 32'(bus.locked), 32'd1);
        check("t6_sync_err", 32'(bus.sync_err), 32'd0);
        idle(2);
        check("t6_pulses", 32'(pulse_cnt - pc), 32'd1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of the team's 8:1 time-division mux link.
- Takes one serial bit per valid beat plus a frame-sync marker and steers each bit into its channel slot.
- Presents a complete registered 8-bit parallel frame with a one-cycle valid pulse.
- Tracks frame alignment and flags sync errors; sits between the serial link and the parallel consumer logic.

Parameters:
- N_CH, 8, number of channels per frame (power of 2, ≥2).
- SEL_W, 3, slot counter width, equal to $clog2(N_CH).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_bit  input  1  serial data bit for the current slot.
- in_valid  input  1  in_bit/frame_sync qualify this cycle.
- frame_sync  input  1  marks the beat carrying slot 0; ignored when in_valid=0.
- q  output  N_CH  last complete frame; q[k] = bit received in slot k.
- q_valid  output  1  one-cycle pulse, q updated this cycle.
- sel  output  SEL_W  slot index the next valid beat is written to.
- locked  output  1  1 while in LOCKED state.
- sync_err  output  1  sticky alignment-error flag.

Behaviour:
- Reset (rst=1 at clk edge): q=0, q_valid=0, sel=0, locked=0, sync_err=0, shadow register=0, state=HUNT. rst has priority over all other inputs.
- Cycles with in_valid=0: no state, sel, shadow or q change; q_valid=0.
- Shadow register: N_CH bits that collect the frame in progress. q changes only on frame completion.
- FSM HUNT:
  - Valid beat with frame_sync=0: discarded.
  - Valid beat with frame_sync=1: shadow[0]=in_bit, sel=1, state -> LOCKED, locked=1 next cycle.
- FSM LOCKED, valid beat, sel=s:
  - frame_sync=0, s≠0: shadow[s]=in_bit, sel=s+1 (mod N_CH).
  - frame_sync=0, s=0 (expected sync missing): beat discarded, sync_err=1, state -> HUNT, locked=0, sel=0, shadow cleared.
  - frame_sync=1, s=0: normal frame start; shadow[0]=in_bit, sel=1.
  - frame_sync=1, s≠0 (early sync): sync_err=1; partial frame discarded (shadow cleared, q not updated); beat taken as new slot 0: shadow[0]=in_bit, sel=1; stays LOCKED.
- Frame completion (LOCKED, valid beat at s=N_CH-1 with frame_sync=0):
  - Next edge: q = shadow with bit N_CH-1 = in_bit, q_valid=1 for exactly one cycle.
  - sel wraps to 0; shadow cleared.
  - Latency from last beat to q/q_valid: 1 clock.
- Back-to-back frames with in_valid held high: one q_valid pulse every N_CH cycles, no bubble required.
- q holds its value indefinitely between completions and across HUNT periods.
- sync_err is sticky; cleared only by rst.
- Reset mid-frame: partial frame lost, q cleared, next frame requires frame_sync.
- sel width rule: counter arithmetic modulo N_CH; no out-of-range index possible.

Test Plan:
- Reset then idle -> q=0, q_valid=0, sel=0, locked=0, sync_err=0 for 20 cycles.
- Send sync+bits 1,0,1,1,0,0,1,0 (slots 0..7) contiguous -> one cycle after slot-7 beat: q=8'b0100_1101, q_valid pulse width 1, sel=0, locked=1, sync_err=0.
- Two frames 8'hA5 then 8'h3C with in_valid toggling 1,0 per cycle -> q=8'hA5 then 8'h3C, exactly two pulses, q stable between them.
- Early sync at slot 4 of a frame, then full frame 8'hFF -> no q_valid for the partial frame, sync_err=1, q=8'hFF after the new frame, locked stays 1.
- Beats in HUNT without sync (8 beats), then missing sync at slot 0 after one good frame 8'h81 -> q=8'h81 only, locked drops to 0, sync_err=1, sel=0.
- rst asserted at slot 5 -> all outputs return to reset values next cycle; next frame 8'h0F decoded correctly after sync.
